// File: rtl/shared_register_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register written by N requesters (optional lock: SHARED_REG_ARB_LOCK_EN).
// Latency: the winner's REQ/D are sampled at edge k, and O/ACK/OWNER update at that same edge.
// Backpressure: losers hold REQ until granted; a requester is masked in its own ACK cycle unless it holds the lock.
module shared_register_arbiter #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    parameter int INIT  = 0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [N-1:0]          REQ,
    input  logic [N*WIDTH-1:0]    D,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic [N-1:0]          LOCK,
`endif
    output logic [WIDTH-1:0]      O,
    output logic [N-1:0]          ACK,
    output logic [$clog2(N)-1:0]  OWNER,
    output logic                  BUSY
);

    localparam int IW = $clog2(N);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

`ifdef SHARED_REG_ARB_LOCK_EN
    typedef enum logic {ST_IDLE, ST_LOCKED} state_t;
    state_t state_q, state_d;
`endif

    logic [WIDTH-1:0] o_q, o_d;
    logic [N-1:0]     ack_q, ack_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic [N-1:0]     ereq;
    logic             win_vld;
    logic [IW-1:0]    win;
    int               idx;

    // Index following x, wrapping N-1 back to 0.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
        return (x == IW'(N - 1)) ? '0 : x + 1'b1;
    endfunction

    // Round-robin search from ptr_q; descending scan so the nearest set index wins.
    always_comb begin
        ereq    = REQ & ~ack_q;
        win_vld = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (ereq[idx]) begin
                win_vld = 1'b1;
                win     = IW'(idx);
            end
        end
    end

    // Next-state: grant and register load, plus lock hold/release when built.
    always_comb begin
        o_d     = o_q;
        ack_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
`ifdef SHARED_REG_ARB_LOCK_EN
        state_d = state_q;
        if (state_q == ST_LOCKED) begin
            // Lock holder may write every cycle; its own ACK does not mask it here.
            if (REQ[owner_q]) begin
                o_d            = D[owner_q*WIDTH +: WIDTH];
                ack_d[owner_q] = 1'b1;
            end
            if (!LOCK[owner_q]) begin
                state_d = ST_IDLE;
                ptr_d   = next_idx(owner_q);
            end
        end else if (win_vld) begin
            o_d        = D[win*WIDTH +: WIDTH];
            ack_d[win] = 1'b1;
            owner_d    = win;
            ptr_d      = next_idx(win);
            if (LOCK[win]) state_d = ST_LOCKED;
        end
`else
        if (win_vld) begin
            o_d        = D[win*WIDTH +: WIDTH];
            ack_d[win] = 1'b1;
            owner_d    = win;
            ptr_d      = next_idx(win);
        end
`endif
    end

    // State registers; reset clears any ACK in flight and drops the lock immediately.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            o_q     <= INIT_V;
            ack_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef SHARED_REG_ARB_LOCK_EN
            state_q <= ST_IDLE;
`endif
        end else begin
            o_q     <= o_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
`ifdef SHARED_REG_ARB_LOCK_EN
            state_q <= state_d;
`endif
        end
    end

    assign O     = o_q;
    assign ACK   = ack_q;
    assign OWNER = owner_q;
`ifdef SHARED_REG_ARB_LOCK_EN
    assign BUSY  = (state_q == ST_LOCKED);
`else
    assign BUSY  = 1'b0;
`endif

endmodule

// File: tb/tb_shared_register_arbiter.sv
// Directed bench for shared_register_arbiter with WIDTH=3, N=4, INIT=5.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Lock scenario is exercised only when SHARED_REG_ARB_LOCK_EN is defined.
module tb_shared_register_arbiter;

    localparam int WIDTH = 3;
    localparam int N     = 4;

    logic             CLK = 1'b0;
    logic             RESETN;
    logic [N-1:0]     REQ;
    logic [N*WIDTH-1:0] D;
`ifdef SHARED_REG_ARB_LOCK_EN
    logic [N-1:0]     LOCK;
`endif
    logic [WIDTH-1:0] O;
    logic [N-1:0]     ACK;
    logic [1:0]       OWNER;
    logic             BUSY;

    int vectors    = 0;
    int miscompares = 0;

    shared_register_arbiter #(.WIDTH(WIDTH), .N(N), .INIT(5)) dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .REQ    (REQ),
        .D      (D),
`ifdef SHARED_REG_ARB_LOCK_EN
        .LOCK   (LOCK),
`endif
        .O      (O),
        .ACK    (ACK),
        .OWNER  (OWNER),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [2:0] d3, input logic [2:0] d2,
                         input logic [2:0] d1, input logic [2:0] d0);
        D = {d3, d2, d1, d0};
    endtask

    logic [3:0] rr_ack [5];
    logic [2:0] rr_o   [5];
    logic [1:0] rr_own [5];

    initial begin
        rr_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_o   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        rr_own = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset held with random activity on the inputs.
        RESETN = 1'b0;
        REQ    = 4'($urandom);
        D      = 12'($urandom);
`ifdef SHARED_REG_ARB_LOCK_EN
        LOCK   = 4'($urandom);
`endif
        step();
        REQ = 4'($urandom);
        D   = 12'($urandom);
        step();
        chk("reset_o", O, 5);
        chk("reset_ack", ACK, 0);
        chk("reset_owner", OWNER, 0);
        chk("reset_busy", BUSY, 0);

        // First write after reset release.
`ifdef SHARED_REG_ARB_LOCK_EN
        LOCK = 4'b0000;
`endif
        RESETN = 1'b1;
        REQ    = 4'b0001;
        set_d(0, 0, 0, 3);
        step();
        chk("first_o", O, 3);
        chk("first_ack", ACK, 4'b0001);
        chk("first_owner", OWNER, 0);

        // Round robin from a fresh pointer, all requesters held high.
        RESETN = 1'b0;
        #1;
        RESETN = 1'b1;
        REQ = 4'b1111;
        set_d(4, 3, 2, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rr_ack", ACK, rr_ack[i]);
            chk("rr_o", O, rr_o[i]);
            chk("rr_owner", OWNER, rr_own[i]);
        end

        // Single hog: one write every second cycle.
        REQ = 4'b0100;
        set_d(4, 6, 2, 1);
        step();
        chk("hog_ack0", ACK, 4'b0100);
        chk("hog_o0", O, 6);
        step();
        chk("hog_ack1", ACK, 4'b0000);
        chk("hog_o1", O, 6);
        step();
        chk("hog_ack2", ACK, 4'b0100);

        // Pointer wrap: grant 3, then 0, then 3.
        REQ = 4'b1000;
        set_d(7, 6, 2, 1);
        step();
        chk("wrap_ack3", ACK, 4'b1000);
        chk("wrap_o3", O, 7);
        REQ = 4'b1001;
        set_d(7, 6, 2, 2);
        step();
        chk("wrap_ack0", ACK, 4'b0001);
        chk("wrap_owner0", OWNER, 0);
        chk("wrap_o0", O, 2);
        step();
        chk("wrap_ack3b", ACK, 4'b1000);
        chk("wrap_owner3b", OWNER, 3);

        // Asynchronous reset during an ACK cycle.
        REQ = 4'b0010;
        set_d(7, 6, 1, 2);
        step();
        chk("mid_ack_pre", ACK, 4'b0010);
        chk("mid_o_pre", O, 1);
        RESETN = 1'b0;
        #2;
        chk("mid_ack_rst", ACK, 0);
        chk("mid_o_rst", O, 5);
        chk("mid_owner_rst", OWNER, 0);
        REQ    = 4'b1001;
        RESETN = 1'b1;
        step();
        chk("post_rst_ack", ACK, 4'b0001);
        chk("post_rst_o", O, 2);

`ifdef SHARED_REG_ARB_LOCK_EN
        // Requester 1 locks for four writes while requester 0 waits.
        REQ  = 4'b0011;
        LOCK = 4'b0010;
        set_d(7, 6, 4, 2);
        step();
        chk("lock_ack0", ACK, 4'b0010);
        chk("lock_o0", O, 4);
        chk("lock_busy0", BUSY, 1);
        for (int i = 0; i < 3; i++) begin
            set_d(7, 6, 3'(i + 5), 2);
            step();
            chk("lock_ack", ACK, 4'b0010);
            chk("lock_o", O, i + 5);
            chk("lock_busy", BUSY, 1);
        end
        LOCK = 4'b0000;
        set_d(7, 6, 3, 2);
        step();
        chk("unlock_ack", ACK, 4'b0010);
        chk("unlock_o", O, 3);
        chk("unlock_busy", BUSY, 0);
        step();
        chk("after_lock_ack", ACK, 4'b0001);
        chk("after_lock_o", O, 2);
        chk("after_lock_owner", OWNER, 0);
`else
        REQ = 4'b1111;
        step();
        chk("busy_tied", BUSY, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
